// File: rtl/de_thread_arb.sv
// ============================================================================
// de_thread_arb : two-thread FE1 -> DE0 scheduler, one holding buffer per
// thread, round-robin with burst limit, per-thread halt and flush.
// Rev 1.0
// ============================================================================
`default_nettype none

module de_thread_arb #(
  parameter int NTHR  = 2,
  parameter int PKT_W = 96,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NTHR-1:0]       fe_valid,
  input  logic [NTHR*PKT_W-1:0] fe_pkt,
  output logic [NTHR-1:0]       fe_ready,
  input  logic                  decode_ready_de0,
  output logic                  valid_fe1,
  output logic [PKT_W-1:0]      instr_fe1,
  output logic                  tid_fe1,
  input  logic                  nuke_valid,
  input  logic                  nuke_tid,
  input  logic                  halt_valid,
  input  logic                  halt_tid,
  output logic [NTHR-1:0]       halted
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } thr_state_t;

  thr_state_t                   state [NTHR];
  logic [NTHR-1:0]              hold_v;
  logic [NTHR-1:0][PKT_W-1:0]   hold_pkt;
  logic [NTHR-1:0]              flush;
  logic [NTHR-1:0]              push;
  logic [NTHR-1:0]              pop;
  logic [NTHR-1:0]              elig;
  logic                         rr_last;
  logic [3:0]                   burst_cnt;
  logic                         gnt_v;
  logic                         gnt_tid;

  generate
    for (genvar t = 0; t < NTHR; t++) begin : g_thr
      assign flush[t]    = nuke_valid & (nuke_tid == 1'(t));
      assign pop[t]      = gnt_v & (gnt_tid == 1'(t));
      assign fe_ready[t] = ~reset & (~hold_v[t] | pop[t]);
      assign push[t]     = fe_valid[t] & fe_ready[t] & ~flush[t];
      assign elig[t]     = hold_v[t] & (state[t] == ST_RUN) & ~flush[t];
      assign halted[t]   = ~reset & (state[t] == ST_HALTED);
    end
  endgenerate

  // Stay on rr_last until it has had BURST grants in a row, then hand over.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_tid = 1'b0;
    if (!reset && decode_ready_de0) begin
      if (elig[0] && elig[1]) begin
        gnt_v   = 1'b1;
        gnt_tid = (burst_cnt < 4'(BURST - 1)) ? rr_last : ~rr_last;
      end else if (elig[0]) begin
        gnt_v   = 1'b1;
        gnt_tid = 1'b0;
      end else if (elig[1]) begin
        gnt_v   = 1'b1;
        gnt_tid = 1'b1;
      end
    end
  end

  assign valid_fe1 = gnt_v;
  assign tid_fe1   = gnt_v & gnt_tid;
  assign instr_fe1 = gnt_v ? hold_pkt[gnt_tid] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v    <= '0;
      rr_last   <= 1'b1;
      burst_cnt <= 4'd0;
      for (int t = 0; t < NTHR; t++) begin
        state[t] <= ST_RUN;
      end
    end else begin
      for (int t = 0; t < NTHR; t++) begin
        if (flush[t]) begin
          hold_v[t] <= 1'b0;
        end else if (push[t]) begin
          hold_v[t]   <= 1'b1;
          hold_pkt[t] <= fe_pkt[t*PKT_W +: PKT_W];
        end else if (pop[t]) begin
          hold_v[t] <= 1'b0;
        end
        // Flush beats a same-cycle halt and releases a halted thread.
        if (flush[t]) begin
          state[t] <= ST_RUN;
        end else if (halt_valid && (halt_tid == 1'(t))) begin
          state[t] <= ST_HALTED;
        end
      end
      if (gnt_v) begin
        rr_last <= gnt_tid;
        if (gnt_tid != rr_last) begin
          burst_cnt <= 4'd0;
        end else if (burst_cnt != 4'hF) begin
          burst_cnt <= burst_cnt + 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_de_thread_arb.sv
// ============================================================================
// tb_de_thread_arb : directed self-checking bench for de_thread_arb.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_de_thread_arb;
  localparam int PKT_W = 96;
  localparam int BURST = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           fe_valid;
  logic [2*PKT_W-1:0]   fe_pkt;
  logic [1:0]           fe_ready;
  logic                 decode_ready_de0;
  logic                 valid_fe1;
  logic [PKT_W-1:0]     instr_fe1;
  logic                 tid_fe1;
  logic                 nuke_valid;
  logic                 nuke_tid;
  logic                 halt_valid;
  logic                 halt_tid;
  logic [1:0]           halted;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_push [2];
  logic [8:0] seq;
  logic       g;

  always #5 clk = ~clk;

  de_thread_arb #(.NTHR(2), .PKT_W(PKT_W), .BURST(BURST)) dut (
    .clk              (clk),
    .reset            (reset),
    .fe_valid         (fe_valid),
    .fe_pkt           (fe_pkt),
    .fe_ready         (fe_ready),
    .decode_ready_de0 (decode_ready_de0),
    .valid_fe1        (valid_fe1),
    .instr_fe1        (instr_fe1),
    .tid_fe1          (tid_fe1),
    .nuke_valid       (nuke_valid),
    .nuke_tid         (nuke_tid),
    .halt_valid       (halt_valid),
    .halt_tid         (halt_tid),
    .halted           (halted)
  );

  function automatic logic [PKT_W-1:0] pk(int t, int c);
    return {32'(t), 32'h00C0_FFEE, 32'(c)};
  endfunction

  task automatic cmp(string tag, logic [127:0] obs, logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // Packets carry (thread, cycle) so every held entry is traceable.
  task automatic drive(logic [1:0] v, logic rdy, logic nv = 1'b0, logic nt = 1'b0,
                       logic hv = 1'b0, logic ht = 1'b0);
    fe_valid         = v;
    decode_ready_de0 = rdy;
    fe_pkt           = {pk(1, cyc), pk(0, cyc)};
    nuke_valid       = nv;
    nuke_tid         = nt;
    halt_valid       = hv;
    halt_tid         = ht;
    #1;
  endtask

  task automatic out(string tag, logic v, logic t, logic [PKT_W-1:0] ins);
    cmp({tag, "_valid"}, 128'(valid_fe1), 128'(v));
    cmp({tag, "_tid"},   128'(tid_fe1),   128'(t));
    cmp({tag, "_instr"}, 128'(instr_fe1), 128'(ins));
  endtask

  initial begin
    reset = 1'b1;
    drive(2'b11, 1'b1);
    tick;
    cmp("rst_fe_ready", 128'(fe_ready), 128'(2'b00));
    out("rst", 1'b0, 1'b0, '0);
    cmp("rst_halted", 128'(halted), 128'(2'b00));
    reset = 1'b0;
    cyc   = 1;

    // Single packet latency.
    drive(2'b01, 1'b1);
    cmp("c1_fe_ready", 128'(fe_ready), 128'(2'b11));
    cmp("c1_valid", 128'(valid_fe1), 128'(1'b0));
    tick;
    drive(2'b00, 1'b1);
    out("c2", 1'b1, 1'b0, pk(0, 1));
    cmp("c2_fe_ready0", 128'(fe_ready[0]), 128'(1'b1));
    tick;

    // Continuous streaming from both threads.
    drive(2'b11, 1'b1);
    cmp("c3_valid", 128'(valid_fe1), 128'(1'b0));
    tick;
    last_push[0] = 3;
    last_push[1] = 3;
    seq = 9'b001111000;
    for (int k = 0; k < 9; k++) begin
      drive(2'b11, 1'b1);
      g = seq[k];
      out($sformatf("stream%0d", k), 1'b1, g, pk(int'(g), last_push[int'(g)]));
      last_push[int'(g)] = cyc;
      tick;
    end

    // Decoder backpressure: nothing moves.
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 1'b0);
      cmp($sformatf("stall%0d_fe_ready", k), 128'(fe_ready), 128'(2'b00));
      cmp($sformatf("stall%0d_valid", k), 128'(valid_fe1), 128'(1'b0));
      tick;
    end
    drive(2'b01, 1'b1);
    out("unstall", 1'b1, 1'b0, pk(0, last_push[0]));
    cmp("unstall_fe_ready", 128'(fe_ready), 128'(2'b01));
    tick;

    // Flush thread 0 while it is the preferred grant.
    drive(2'b01, 1'b1, 1'b1, 1'b0);
    out("nuke0", 1'b1, 1'b1, pk(1, last_push[1]));
    cmp("nuke0_fe_ready", 128'(fe_ready), 128'(2'b10));
    tick;
    drive(2'b01, 1'b1, 1'b1, 1'b0);
    out("nuke0_empty", 1'b0, 1'b0, '0);
    cmp("nuke0_empty_fe_ready", 128'(fe_ready), 128'(2'b11));
    tick;
    drive(2'b11, 1'b1);
    out("after_nuke", 1'b0, 1'b0, '0);
    tick;
    drive(2'b10, 1'b1);
    out("rr_keep", 1'b1, 1'b1, pk(1, 19));
    tick;

    // Halt thread 1 while it holds a packet.
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cmp("halt_valid", 128'(valid_fe1), 128'(1'b0));
    cmp("halt_pre", 128'(halted), 128'(2'b00));
    tick;
    drive(2'b01, 1'b1);
    cmp("halted1", 128'(halted), 128'(2'b10));
    out("halt_g0", 1'b1, 1'b0, pk(0, 19));
    cmp("halt_fe_ready", 128'(fe_ready), 128'(2'b01));
    tick;
    drive(2'b01, 1'b1);
    out("halt_g1", 1'b1, 1'b0, pk(0, 22));
    tick;
    drive(2'b00, 1'b1);
    out("halt_g2", 1'b1, 1'b0, pk(0, 23));
    tick;
    drive(2'b00, 1'b1, 1'b1, 1'b1);
    cmp("unhalt_pre", 128'(halted), 128'(2'b10));
    out("unhalt_pre", 1'b0, 1'b0, '0);
    tick;
    drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("unhalt", 128'(halted), 128'(2'b00));
    cmp("unhalt_fe_ready", 128'(fe_ready), 128'(2'b11));
    out("unhalt", 1'b0, 1'b0, '0);
    tick;

    // Reset with both buffers full and thread 0 halted.
    reset = 1'b1;
    drive(2'b11, 1'b1);
    out("midrst", 1'b0, 1'b0, '0);
    cmp("midrst_fe_ready", 128'(fe_ready), 128'(2'b00));
    cmp("midrst_halted", 128'(halted), 128'(2'b00));
    tick;
    reset = 1'b0;
    drive(2'b01, 1'b1);
    out("postrst", 1'b0, 1'b0, '0);
    cmp("postrst_fe_ready", 128'(fe_ready), 128'(2'b11));
    cmp("postrst_halted", 128'(halted), 128'(2'b00));
    tick;
    drive(2'b11, 1'b1);
    out("postrst_g0", 1'b1, 1'b0, pk(0, 28));
    tick;
    drive(2'b00, 1'b1);
    out("postrst_g1", 1'b1, 1'b0, pk(0, 29));
    tick;
    drive(2'b00, 1'b1);
    out("postrst_g2", 1'b1, 1'b1, pk(1, 29));
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
